// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter
// Round-robin front end that shares one iterative AES-128 core among N_REQ
// requesters. One job is in flight at a time. The core's fixed 11-cycle
// latency is tracked locally. Results return through a 2-entry response FIFO,
// tagged with the ID of the requester that issued them.
module aes_req_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*128-1:0] req_data,
    input  logic [N_REQ*128-1:0] req_key,
    output logic                 aes_valid_o,
    output logic [127:0]         aes_data_o,
    output logic [127:0]         aes_key_o,
    input  logic                 aes_res_valid_i,
    input  logic [127:0]         aes_res_i,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [127:0]         rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy_o,
    output logic                 err_o
);

    // Count value on the cycle the core presents its result.
    localparam logic [3:0] LAST_CNT = 4'd11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [3:0]      cnt_reg;
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] launch_id_reg;
    logic            err_reg;

    logic [127:0]    data_arr [N_REQ];
    logic [127:0]    key_arr  [N_REQ];

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    int              cand;
    logic            launch;
    logic            done_cycle;

    logic [127:0]    fifo_data_reg [2];
    logic [ID_W-1:0] fifo_id_reg   [2];
    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [1:0]      fifo_cnt_reg;
    logic            push;
    logic            pop;

    // Unpack the flat per-requester buses into indexable arrays.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*128 +: 128];
            assign key_arr[gi]  = req_key[gi*128 +: 128];
        end
    endgenerate

    // Find the first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_ptr_reg) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_found && req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // A launch needs the core idle and FIFO room based on the registered count.
    // The result arrives on done_cycle.
    assign launch     = (state_reg == IDLE) && grant_found && (fifo_cnt_reg != 2'd2);
    assign done_cycle = (state_reg == RUN) && (cnt_reg == LAST_CNT);
    assign push       = done_cycle && aes_res_valid_i;
    assign pop        = (fifo_cnt_reg != 2'd0) && rsp_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic. RUN always lasts exactly until the result cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch)     state_next = RUN;
            RUN:     if (done_cycle) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs. The core and the granted requester see the launch in the same cycle.
    always_comb begin
        req_ready   = '0;
        aes_valid_o = 1'b0;
        aes_data_o  = '0;
        aes_key_o   = '0;
        if (launch) begin
            req_ready[grant_idx] = 1'b1;
            aes_valid_o          = 1'b1;
            aes_data_o           = data_arr[grant_idx];
            aes_key_o            = key_arr[grant_idx];
        end
    end

    assign busy_o = (state_reg == RUN);

    // Latency counter, round-robin pointer and in-flight job ID.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_reg       <= '0;
            rr_ptr_reg    <= '0;
            launch_id_reg <= '0;
        end else if (launch) begin
            cnt_reg       <= 4'd1;
            launch_id_reg <= grant_idx;
            rr_ptr_reg    <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end else if (state_reg == RUN) begin
            cnt_reg <= done_cycle ? 4'd0 : cnt_reg + 4'd1;
        end
    end

    // Sticky protocol error: the result is missing on the done cycle, or it arrives on any other cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_reg <= 1'b0;
        end else if (aes_res_valid_i != done_cycle) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;

    // Response FIFO storage. A push always has room because only one job is in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_id_reg[i]   <= '0;
            end
        end else if (push) begin
            fifo_data_reg[wr_ptr_reg] <= aes_res_i;
            fifo_id_reg[wr_ptr_reg]   <= launch_id_reg;
        end
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            fifo_cnt_reg <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    assign rsp_valid = (fifo_cnt_reg != 2'd0);
    assign rsp_data  = fifo_data_reg[rd_ptr_reg];
    assign rsp_id    = fifo_id_reg[rd_ptr_reg];

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin controller that shares one iterative AES-128 encryption core among `N_REQ` requesters. It accepts one request at a time over a valid/ready handshake and launches the core only when the core is idle. It tracks the core's fixed 11-cycle latency with its own counter, and returns each ciphertext with the requester's ID through a 2-entry response FIFO. It sits between the requester ports and the core's `data_valid_in`/`data_in`/`key_in` and `res_valid_out`/`res_enc_out` pins.

## Interface
- `N_REQ`, default 4 — number of requesters, range 2..16.
- `ID_W`, default `$clog2(N_REQ)` — width of the requester ID.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low. The same signal also resets the core.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit set in any cycle.
- `req_data`  in  N_REQ*128  plaintexts; requester k occupies `[k*128+127:k*128]`.
- `req_key`  in  N_REQ*128  keys; same packing as `req_data`.
- `aes_valid_o`  out  1  launch pulse to the core's `data_valid_in`.
- `aes_data_o`, `aes_key_o`  out  128 each  plaintext and key of the granted requester.
- `aes_res_valid_i`  in  1  core `res_valid_out`.
- `aes_res_i`  in  128  core `res_enc_out`.
- `rsp_valid`  out  1  response FIFO not empty.
- `rsp_ready`  in  1  consumer pop.
- `rsp_data`  out  128  ciphertext at the FIFO head.
- `rsp_id`  out  ID_W  requester ID at the FIFO head.
- `busy_o`  out  1  a job is in flight in the core.
- `err_o`  out  1  sticky core-protocol error.

## Operation
- FSM states: IDLE and RUN. A 4-bit counter `cnt` is used only in RUN.
- **IDLE, launch condition:** a launch occurs when any `req_valid` is high and FIFO count < 2.
  - The grant goes to the first valid requester at or after `rr_ptr`, searching upward with wrap.
  - Same cycle: `aes_valid_o`=1, `req_ready[g]`=1, and `aes_data_o`/`aes_key_o` carry requester g's inputs.
  - At the clock edge: `rr_ptr` ← (g+1) mod N_REQ, the launch ID is latched, `cnt` ← 1, state → RUN.
- **IDLE, no launch:** `aes_valid_o`=0, all `req_ready`=0, `aes_data_o`/`aes_key_o`=0.
- **RUN:**
  - `cnt` increments each cycle.
  - `aes_valid_o` stays 0 for the whole of RUN; a launch in RUN would corrupt the core.
  - When `cnt`==11: `aes_res_i` and the latched ID are pushed into the FIFO, state → IDLE.
- **Protocol errors** (each sets `err_o`, which holds until reset):
  - `aes_res_valid_i` is 0 when `cnt`==11. Nothing is pushed, and the FSM still returns to IDLE.
  - `aes_res_valid_i` is 1 at any other time. It is ignored.
- **FIFO:** 2 entries, in order.
  - A pop happens when `rsp_valid && rsp_ready`.
  - A push is guaranteed to have space: launch requires count ≤1 and only one job is in flight.
  - Push and pop in the same cycle leave the count unchanged.
- `busy_o` = (state==RUN).
- Requesters may drop `req_valid` before being granted. A dropped request is never launched.

## Timing
- **Reset values:** state IDLE, `rr_ptr`=0, FIFO empty, `err_o`=0, `busy_o`=0. All outputs are 0.
- **Latency:** launch in cycle c → `aes_res_valid_i` expected in cycle c+11 → `rsp_valid` in cycle c+12.
- **Next launch:** earliest in cycle c+12, which is the first IDLE cycle. This matches the core returning to its idle state after its done cycle.
- **Throughput:** one block per 12 cycles while the FIFO keeps draining.
- **Backpressure:**
  - If the FIFO holds 2 entries, no launch occurs.
  - A pop in cycle t allows a launch in cycle t+1. FIFO space is sampled as the registered count.
- **Combinational paths:** `req_ready` and `aes_valid_o` depend on `req_valid` combinationally. There is no path from `rsp_ready` to `req_ready`.
- **Reset mid-RUN:** everything returns to its reset value on the next edge. The in-flight job and FIFO contents are discarded, and no response is produced.
- **Simultaneous events:**
  - A grant and a FIFO push cannot coincide, because a push happens in RUN.
  - A pop and the cnt==11 push in the same cycle: both take effect.

## Test plan
The bench core model returns `aes_data_o ^ aes_key_o` with `aes_res_valid_i` high exactly 11 cycles after the launch, unless a scenario says otherwise.
- **Single request:** requester 2 sends data=0x00112233445566778899aabbccddeeff, key=0x000102030405060708090a0b0c0d0e0f at cycle 5, with `rsp_ready`=1.
  - `req_ready[2]` and `aes_valid_o` are high in cycle 5.
  - `rsp_valid` is high in cycle 17 with `rsp_data`=0x00102030405060708090a0b0c0d0e0f0 and `rsp_id`=2.
- **All four requesters valid continuously from reset:**
  - Grants go to 0,1,2,3,0 at cycles 0,12,24,36,48.
  - Responses come out in the same order.
- **`rsp_ready`=0 with three requests pending:**
  - Launches at cycles 0 and 12, and the FIFO fills at cycle 24.
  - No launch occurs while the FIFO is full.
  - Raising `rsp_ready` at cycle 30 pops one entry, and the next launch occurs at cycle 31.
- **Core model holds `aes_res_valid_i` low at cnt==11:** `err_o`=1 from the next cycle, no FIFO push, and the next request launches one cycle later.
- **`resetn` driven low at cnt==6:**
  - Next cycle: `busy_o`=0, `rsp_valid`=0, `rr_ptr`=0.
  - A stray `aes_res_valid_i` arriving 5 cycles later sets `err_o`=1 and produces no push.
